dff: RTL and testbench
======================

DFF -- requirements
Module: dff

Interface
REQ-001 Parameter WIDTH, default 1: bit width of d and out; legal values are 1 or greater.
REQ-002 Parameter RESET_VALUE, default all-zeros of WIDTH bits: value loaded into out while clr is sampled high.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port clr, input, 1 bit: synchronous, active-high clear.
REQ-005 Port d, input, WIDTH bits: data to capture.
REQ-006 Port out, output, WIDTH bits: registered value.
REQ-007 The block SHALL have one clock (clk) and a synchronous, active-high reset (clr); no other ports SHALL exist.

Function
REQ-008 On each rising clk edge with clr=0, out SHALL take the value of d sampled at that edge; latency is one cycle.
REQ-009 On each rising clk edge with clr=1, out SHALL take RESET_VALUE regardless of d.
REQ-010 Between rising edges, out SHALL hold its value; changes on d or clr SHALL have no effect until the next rising edge.
REQ-011 clr=1 coincident with any d value SHALL resolve to clear, because clear has priority.
REQ-012 out SHALL be driven directly from the register, with no combinational path from d or clr to out.
REQ-013 All WIDTH bits SHALL update together on the same edge; bits SHALL NOT be reordered or extended.
REQ-014 Before the first rising edge with clr=1, out is unspecified (X in simulation); no initial value SHALL be relied upon.

Reset
REQ-015 Reset SHALL be synchronous: asserting clr SHALL NOT change out until the next rising clk edge.
REQ-016 Deasserting clr SHALL let the next rising edge capture d normally, with no extra recovery cycle.
REQ-017 If clr is asserted while data is flowing, the stored value SHALL be discarded at the next edge and out SHALL equal RESET_VALUE.
REQ-018 clr held high for N edges SHALL keep out at RESET_VALUE for all N edges.

Structure
REQ-019 No shared package is required; WIDTH and RESET_VALUE SHALL be module parameters.
REQ-020 The block SHALL be a single module with no sub-modules and one clocked process.
REQ-021 Parent blocks (for example, a mux-select stage feeding d) SHALL instantiate dff with named port connections d, clk, clr and out.

Verification
REQ-022 Clock period 10 units; clr=1 and d=1 held for 2 rising edges -> out=0 after the first edge and still 0 after the second edge.
REQ-023 After REQ-022, drop clr to 0 with d=1 -> out=1 after the next rising edge, and stays 1 for 6 further edges.
REQ-024 clr=0, d toggled 1,0,1,1,0 on successive edges -> out follows the same sequence, delayed by exactly one edge.
REQ-025 clr=0, d changed mid-cycle (between edges) -> out unchanged until the next rising edge.
REQ-026 out=1 steady, clr pulsed high for one cycle with d=1 -> out=0 for exactly one cycle, then 1 again.
REQ-027 WIDTH=8, RESET_VALUE=8'hA5, d=8'h3C -> out=8'hA5 under clr=1, then out=8'h3C one edge after clr is released.

Source files
------------

// File: rtl/dff.sv
// Parameterised D flip-flop with a synchronous, active-high clear.
// The clear has priority over d, and out comes straight from the register.
module dff #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;

   always_comb begin
      out_d = d;
      if (clr) begin
         out_d = RESET_VALUE;
      end
   end

   always_ff @(posedge clk) begin
      out_q <= out_d;
   end

   assign out = out_q;

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: a 1-bit default instance and an 8-bit instance with a non-zero reset value.
module tb_dff;

   logic       clk;
   logic       clr;
   logic       d1;
   logic [7:0] d8;
   logic       out1;
   logic [7:0] out8;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic       clr;
      logic       d1;
      logic [7:0] d8;
      logic       exp1;
      logic [7:0] exp8;
   } vec_t;

   typedef struct {
      string      name;
      logic       exp1;
      logic [7:0] exp8;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vecs[$];

   dff u_dff1 (
      .clk (clk),
      .clr (clr),
      .d   (d1),
      .out (out1)
   );

   dff #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dff8 (
      .clk (clk),
      .clr (clr),
      .d   (d8),
      .out (out8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s out1: actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s out8: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, queue the expectation, compare 1 time unit after the rising edge.
   task automatic step(input string name, input logic c, input logic v1, input logic [7:0] v8,
                       input logic e1, input logic [7:0] e8);
      sb_t item;
      @(negedge clk);
      clr = c;
      d1  = v1;
      d8  = v8;
      item.name = name;
      item.exp1 = e1;
      item.exp8 = e8;
      sb_q.push_back(item);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard: actual=empty required=entry", name);
      end else begin
         item = sb_q.pop_front();
         check1(item.name, out1, item.exp1);
         check8(item.name, out8, item.exp8);
      end
   endtask

   task automatic add(input logic c, input logic v1, input logic [7:0] v8,
                      input logic e1, input logic [7:0] e8);
      vec_t v;
      v.clr  = c;
      v.d1   = v1;
      v.d8   = v8;
      v.exp1 = e1;
      v.exp8 = e8;
      vecs.push_back(v);
   endtask

   initial begin
      clr = 1'b0;
      d1  = 1'b0;
      d8  = 8'h00;

      // clr and d high together for two edges: clear wins both times
      add(1'b1, 1'b1, 8'h3C, 1'b0, 8'hA5);
      add(1'b1, 1'b1, 8'h3C, 1'b0, 8'hA5);
      // release clr: capture on the very next edge, then hold for 6 more
      for (int unsigned i = 0; i < 7; i++) add(1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C);
      // data sequence follows d with one-edge latency
      add(1'b0, 1'b1, 8'h81, 1'b1, 8'h81);
      add(1'b0, 1'b0, 8'h7E, 1'b0, 8'h7E);
      add(1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF);
      add(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
      add(1'b0, 1'b0, 8'h5A, 1'b0, 8'h5A);
      // steady 1 then a single-cycle clr pulse with d=1
      add(1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3);
      add(1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3);
      add(1'b1, 1'b1, 8'hC3, 1'b0, 8'hA5);
      add(1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3);
      add(1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3);
      // clear with all-zero data still yields the reset value
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'hA5);
      add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].clr, vecs[i].d1, vecs[i].d8,
              vecs[i].exp1, vecs[i].exp8);
      end

      // Load a known value before the mid-cycle sequence.
      step("mid_load", 1'b0, 1'b1, 8'h96, 1'b1, 8'h96);

      // d and clr changing between edges must not disturb out until the next edge.
      @(negedge clk);
      d1 = 1'b0;
      d8 = 8'h11;
      #2;
      check1("mid_d_change", out1, 1'b1);
      check8("mid_d_change", out8, 8'h96);
      clr = 1'b1;
      #1;
      check1("mid_clr_assert", out1, 1'b1);
      check8("mid_clr_assert", out8, 8'h96);
      @(posedge clk);
      #1;
      check1("mid_clr_edge", out1, 1'b0);
      check8("mid_clr_edge", out8, 8'hA5);

      // Deassert clr mid-cycle: output holds the reset value until the next edge captures d.
      @(negedge clk);
      clr = 1'b0;
      d1  = 1'b1;
      d8  = 8'hE7;
      #1;
      check1("mid_clr_release", out1, 1'b0);
      check8("mid_clr_release", out8, 8'hA5);
      @(posedge clk);
      #1;
      check1("mid_release_edge", out1, 1'b1);
      check8("mid_release_edge", out8, 8'hE7);

      // A short random burst checked against the clear-priority reference.
      for (int unsigned i = 0; i < 20; i++) begin
         logic       rc;
         logic       r1;
         logic [7:0] r8;
         rc = ($urandom_range(0, 3) == 0);
         r1 = 1'($urandom_range(0, 1));
         r8 = 8'($urandom_range(0, 255));
         step($sformatf("rand%0d", i), rc, r1, r8, rc ? 1'b0 : r1, rc ? 8'hA5 : r8);
      end

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
